// File: rtl/write_packer.sv
// Write-side packer: gathers K input words into one group and hands the group
// to the circular buffer with a single write strobe once the buffer has room.
module write_packer #(
    parameter int DATA_W = 8,
    parameter int K      = 4,
    localparam int IDX_W = $clog2(K),
    localparam int CNT_W = $clog2(K + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_W-1:0]     in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    input  logic                  buf_full_i,
    output logic                  wr_en_o,
    output logic [K*DATA_W-1:0]   wr_data_o,
    output logic [CNT_W-1:0]      wr_cnt_o,
    output logic                  busy_o
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [K-1:0][DATA_W-1:0]     slots_q, slots_d;
    logic [K*DATA_W-1:0]          wr_data_q, wr_data_d;
    logic [CNT_W-1:0]             wr_cnt_q, wr_cnt_d;

    logic                         accept;
    logic [CNT_W-1:0]             fill_cnt;

    assign in_ready_o = rst_ni & (state_q == S_FILL);
    assign accept     = in_valid_i & in_ready_o;
    assign fill_cnt   = CNT_W'(idx_q) + CNT_W'(accept);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_FILL;
            idx_q     <= '0;
            slots_q   <= '0;
            wr_data_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            slots_q   <= slots_d;
            wr_data_q <= wr_data_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        slots_d   = slots_q;
        wr_data_d = wr_data_q;
        wr_cnt_d  = wr_cnt_q;
        wr_en_o   = 1'b0;
        unique case (state_q)
            S_FILL: begin
                if (accept) begin
                    slots_d[idx_q] = in_data_i;
                    idx_d          = idx_q + IDX_W'(1);
                end
                // Slots above idx are always zero, so a partial group is already padded.
                if ((accept && idx_q == IDX_W'(K - 1)) || (flush_i && fill_cnt != '0)) begin
                    state_d   = S_HOLD;
                    wr_cnt_d  = fill_cnt;
                    wr_data_d = slots_d;
                    idx_d     = '0;
                    slots_d   = '0;
                end
            end
            S_HOLD: begin
                if (!buf_full_i) begin
                    wr_en_o   = 1'b1;
                    state_d   = S_FILL;
                    wr_data_d = '0;
                    wr_cnt_d  = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    assign wr_data_o = wr_data_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign busy_o    = (state_q == S_HOLD);

endmodule
